pong_mmio: RTL
==============

Name: pong_mmio

Overview:
Memory-mapped I/O slave between the processor data-memory port and the Pong peripherals; decodes the I/O window above data RAM.
- Consumes PS2 byte strobes: decodes make/break/extended sequences into a key-event FIFO and a held-key bitmap.
- Drives VGA coordinates through vsync-committed shadow registers, so frames never tear.
- Runs entirely in the processor clock domain.

Parameters:
BASE_ADDR, 12'd3000, first I/O word address; window is BASE_ADDR..BASE_ADDR+7
FIFO_DEPTH, 8, key-event FIFO entries (power of two, >=2)
PADDLE_MAX, 9'd400, largest legal paddle top y (480 minus paddle height 80)

Ports:
clock  in  1  processor clock (shared with dmem/PS2_Interface)
resetn  in  1  asynchronous active-low reset
addr  in  12  processor dmem address
wdata  in  32  processor store data
wren  in  1  processor store strobe
io_rdata  out  32  registered read data, valid 1 cycle after addr
io_hit  out  1  registered: previous-cycle addr was in window (top muxes io_rdata over dmem q)
ps2_key_pressed  in  1  one-cycle strobe, new scan byte
ps2_key_data  in  8  scan byte accompanying strobe
vga_vsync  in  1  VGA VS (asynchronous, active-low)
ball_x  out  10  displayed ball x
ball_y  out  9  displayed ball y
paddle_left  out  9  displayed left paddle y
paddle_right  out  9  displayed right paddle y

Behaviour:
- Reset: staging and display registers ball 320/240, paddles 200/200; FIFO empty; held=0; frame_cnt=0; overflow=0; commit_pending=0; io_rdata=0; io_hit=0; decoder in IDLE.
- Offsets: +0 BALL_X (W), +1 BALL_Y (W), +2 PADDLE_L (W), +3 PADDLE_R (W), +4 COMMIT (W, any data), +5 STATUS (R: [31:16] frame_cnt, [4] overflow, [3:0] fifo count; W: clears overflow), +6 KEY_EVENT (R: [10] valid, [9] ext, [8] break, [7:0] code, head entry or 0 if empty; W: pop), +7 KEY_HELD (R: [3] Down, [2] Up, [1] S, [0] W).
- Staging writes clamp: x to 639, y to 479, paddles to PADDLE_MAX; wdata upper bits are ignored before the compare only after taking the low 10/9 bits.
- Reads: 1-cycle latency, registered from the current-cycle addr. Unmapped offsets read 0. A write and a read to the same register in one cycle returns the old value.
- Vsync: 2-flop synchroniser, then falling-edge detect gives a one-cycle frame_tick.
- frame_tick: frame_cnt++ (wraps at 16 bits). If commit_pending, display <= staging (pre-write values of the same cycle) and commit_pending clears.
- COMMIT on the same cycle as frame_tick: the copy waits for the next tick.
- Decoder FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). Non-prefix byte pushes {ext,brk,code} and returns to IDLE. E0 in BRK stays BRK. F0 in EXT goes to EXT_BRK.
- Held bitmap updates on the push for W=1D, S=1B, Up=E0 75, Down=E0 72; make sets the bit, break clears it.
- FIFO: push on full without a simultaneous pop drops the event and sets overflow sticky; held still updates. Pop and push together on full: both happen, count unchanged. Pop on empty is ignored.

Optional Feature:
PONG_MMIO_REPEAT_FILTER_EN
- Defined: a make event for a key whose held bit is already 1 is not pushed (typematic repeat suppression, tracked keys only).
- Undefined: every decoded event is pushed.

Decomposition:
- Package pong_mmio_pkg: register offsets, scan-code constants (F0, E0, 1D, 1B, 75, 72), event bit positions, screen limits 639/479, reset coordinates.
- Sub-module key_event_fifo: parameterised synchronous FIFO with count, full/empty, simultaneous push/pop.
- Decoder FSM, vsync sync and register file stay in pong_mmio.

Test Plan:
- Reset release: read STATUS -> 0x00000000; ball_x=320, ball_y=240, paddles=200.
- Write BALL_X=700, PADDLE_L=450, then COMMIT; no vsync -> outputs unchanged. Vsync falling edge -> ball_x=639, paddle_left=400 within 3 clocks; frame_cnt=1.
- Bytes E0,F0,75 after E0,75 -> KEY_EVENT reads 0x675, pop, then 0x775; KEY_HELD=0 after.
- Push 9 make events of 1C with FIFO_DEPTH=8 -> count=8, overflow=1. Write STATUS -> overflow=0. Pop and push same cycle -> count stays 8.
- COMMIT on the same cycle as a vsync edge -> display unchanged until the following edge.
- With PONG_MMIO_REPEAT_FILTER_EN: 1D,1D,1D -> one event queued, held[0]=1. Without it -> three events queued.

Source files
------------

// File: rtl/pong_mmio_pkg.sv
// Shared constants and types for the Pong memory-mapped I/O slave: register
// offsets, PS/2 scan codes, key-event layout, screen limits and reset coordinates.
package pong_mmio_pkg;

  localparam logic [2:0] OFF_BALL_X    = 3'd0;
  localparam logic [2:0] OFF_BALL_Y    = 3'd1;
  localparam logic [2:0] OFF_PADDLE_L  = 3'd2;
  localparam logic [2:0] OFF_PADDLE_R  = 3'd3;
  localparam logic [2:0] OFF_COMMIT    = 3'd4;
  localparam logic [2:0] OFF_STATUS    = 3'd5;
  localparam logic [2:0] OFF_KEY_EVENT = 3'd6;
  localparam logic [2:0] OFF_KEY_HELD  = 3'd7;

  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_W    = 8'h1D;
  localparam logic [7:0] SC_S    = 8'h1B;
  localparam logic [7:0] SC_UP   = 8'h75;
  localparam logic [7:0] SC_DOWN = 8'h72;

  localparam int EV_BRK_BIT   = 8;
  localparam int EV_EXT_BIT   = 9;
  localparam int EV_VALID_BIT = 10;

  localparam int HELD_W    = 0;
  localparam int HELD_S    = 1;
  localparam int HELD_UP   = 2;
  localparam int HELD_DOWN = 3;

  localparam logic [9:0] X_MAX = 10'd639;
  localparam logic [8:0] Y_MAX = 9'd479;

  localparam logic [9:0] BALL_X_RST = 10'd320;
  localparam logic [8:0] BALL_Y_RST = 9'd240;
  localparam logic [8:0] PADDLE_RST = 9'd200;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_BRK,
    DEC_EXT,
    DEC_EXT_BRK
  } dec_state_e;

  // Field order matches the KEY_EVENT read layout below the valid bit.
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  function automatic logic [9:0] clamp10(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [8:0] clamp9(input logic [8:0] v, input logic [8:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous FIFO with occupancy count; a push on full is accepted only when
// a pop happens in the same cycle, and a pop on empty is ignored.
module key_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_full    = (r_count == CNT_FULL);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // NOTE: storage is deliberately not reset; r_count gates every read, so
  // stale entries are never visible and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pong_mmio.sv
// Pong I/O window slave: PS/2 key decoder + event FIFO, vsync-committed VGA
// coordinates and register file. Optional build macro: PONG_MMIO_REPEAT_FILTER_EN.
module pong_mmio
  import pong_mmio_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR  = 12'd3000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [8:0]  PADDLE_MAX = 9'd400
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [11:0] addr,
  input  logic [31:0] wdata,
  input  logic        wren,
  output logic [31:0] io_rdata,
  output logic        io_hit,
  input  logic        ps2_key_pressed,
  input  logic [7:0]  ps2_key_data,
  input  logic        vga_vsync,
  output logic [9:0]  ball_x,
  output logic [8:0]  ball_y,
  output logic [8:0]  paddle_left,
  output logic [8:0]  paddle_right
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- address decode ----------------
  logic [11:0] w_addr_rel;
  logic [2:0]  w_offset;
  logic        w_in_window;
  logic        w_wr;

  assign w_addr_rel  = addr - BASE_ADDR;
  assign w_offset    = w_addr_rel[2:0];
  assign w_in_window = (addr >= BASE_ADDR) && (addr <= BASE_ADDR + 12'd7);
  assign w_wr        = wren & w_in_window;

  logic w_unused_wdata;
  assign w_unused_wdata = ^{wdata[31:10], w_addr_rel[11:3]};

  // ---------------- vsync synchroniser / frame tick ----------------
  logic r_vs_meta, r_vs_sync, r_vs_prev;
  logic w_frame_tick;

  // Idle-high reset values keep a reset release from looking like a falling edge.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_vs_meta <= 1'b1;
      r_vs_sync <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_vs_meta <= vga_vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
    end
  end

  assign w_frame_tick = r_vs_prev & ~r_vs_sync;

  // ---------------- staging / display registers ----------------
  logic [9:0]  r_stg_x;
  logic [8:0]  r_stg_y, r_stg_pl, r_stg_pr;
  logic [9:0]  r_disp_x;
  logic [8:0]  r_disp_y, r_disp_pl, r_disp_pr;
  logic        r_commit_pending;
  logic [15:0] r_frame_cnt;

  // Display copies the staging values held before this cycle's writes land.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stg_x          <= BALL_X_RST;
      r_stg_y          <= BALL_Y_RST;
      r_stg_pl         <= PADDLE_RST;
      r_stg_pr         <= PADDLE_RST;
      r_disp_x         <= BALL_X_RST;
      r_disp_y         <= BALL_Y_RST;
      r_disp_pl        <= PADDLE_RST;
      r_disp_pr        <= PADDLE_RST;
      r_commit_pending <= 1'b0;
      r_frame_cnt      <= '0;
    end else begin
      if (w_frame_tick) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (r_commit_pending) begin
          r_disp_x  <= r_stg_x;
          r_disp_y  <= r_stg_y;
          r_disp_pl <= r_stg_pl;
          r_disp_pr <= r_stg_pr;
        end
      end
      if (w_wr && w_offset == OFF_BALL_X)   r_stg_x  <= clamp10(wdata[9:0], X_MAX);
      if (w_wr && w_offset == OFF_BALL_Y)   r_stg_y  <= clamp9(wdata[8:0], Y_MAX);
      if (w_wr && w_offset == OFF_PADDLE_L) r_stg_pl <= clamp9(wdata[8:0], PADDLE_MAX);
      if (w_wr && w_offset == OFF_PADDLE_R) r_stg_pr <= clamp9(wdata[8:0], PADDLE_MAX);
      // A COMMIT landing on a tick re-arms rather than copying this frame.
      if (w_wr && w_offset == OFF_COMMIT) r_commit_pending <= 1'b1;
      else if (w_frame_tick)              r_commit_pending <= 1'b0;
    end
  end

  assign ball_x       = r_disp_x;
  assign ball_y       = r_disp_y;
  assign paddle_left  = r_disp_pl;
  assign paddle_right = r_disp_pr;

  // ---------------- PS/2 decoder FSM ----------------
  dec_state_e r_dec_state, w_dec_next;
  logic       w_is_brk, w_is_ext;
  logic       w_dec_valid;
  key_event_t w_dec_event;

  assign w_is_brk = (ps2_key_data == SC_BRK);
  assign w_is_ext = (ps2_key_data == SC_EXT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_dec_state <= DEC_IDLE;
    else         r_dec_state <= w_dec_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    w_dec_next = r_dec_state;
    if (ps2_key_pressed) begin
      case (r_dec_state)
        DEC_IDLE:    w_dec_next = w_is_brk ? DEC_BRK : (w_is_ext ? DEC_EXT : DEC_IDLE);
        DEC_BRK:     w_dec_next = (w_is_brk || w_is_ext) ? DEC_BRK : DEC_IDLE;
        DEC_EXT:     w_dec_next = w_is_brk ? DEC_EXT_BRK : (w_is_ext ? DEC_EXT : DEC_IDLE);
        DEC_EXT_BRK: w_dec_next = (w_is_brk || w_is_ext) ? DEC_EXT_BRK : DEC_IDLE;
        default:     w_dec_next = DEC_IDLE;
      endcase
    end
  end

  always_comb begin
    w_dec_valid = 1'b0;
    w_dec_event = '0;
    if (ps2_key_pressed && !w_is_brk && !w_is_ext) begin
      w_dec_valid      = 1'b1;
      w_dec_event.ext  = (r_dec_state == DEC_EXT) || (r_dec_state == DEC_EXT_BRK);
      w_dec_event.brk  = (r_dec_state == DEC_BRK) || (r_dec_state == DEC_EXT_BRK);
      w_dec_event.code = ps2_key_data;
    end
  end

  // ---------------- held-key bitmap ----------------
  logic [3:0] r_held;
  logic [3:0] w_held_hit;

  always_comb begin
    w_held_hit            = '0;
    w_held_hit[HELD_W]    = !w_dec_event.ext && (w_dec_event.code == SC_W);
    w_held_hit[HELD_S]    = !w_dec_event.ext && (w_dec_event.code == SC_S);
    w_held_hit[HELD_UP]   =  w_dec_event.ext && (w_dec_event.code == SC_UP);
    w_held_hit[HELD_DOWN] =  w_dec_event.ext && (w_dec_event.code == SC_DOWN);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)          r_held <= '0;
    else if (w_dec_valid) r_held <= w_dec_event.brk ? (r_held & ~w_held_hit)
                                                    : (r_held | w_held_hit);
  end

  // ---------------- key-event FIFO ----------------
  logic          w_push, w_pop;
  logic [9:0]    w_fifo_rd;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_full, w_fifo_empty;
  logic          r_overflow;

`ifdef PONG_MMIO_REPEAT_FILTER_EN
  logic w_repeat;
  assign w_repeat = !w_dec_event.brk && |(w_held_hit & r_held);
  assign w_push   = w_dec_valid & ~w_repeat;
`else
  assign w_push   = w_dec_valid;
`endif

  assign w_pop = w_wr && (w_offset == OFF_KEY_EVENT);

  key_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(key_event_t))
  ) u_fifo (
    .clk       (clock),
    .rst_n     (resetn),
    .i_push    (w_push),
    .i_wr_data (w_dec_event),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_rd),
    .o_count   (w_fifo_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // A drop in the same cycle as a STATUS write still leaves overflow set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                                r_overflow <= 1'b0;
    else if (w_push && w_fifo_full && !w_pop)   r_overflow <= 1'b1;
    else if (w_wr && w_offset == OFF_STATUS)    r_overflow <= 1'b0;
  end

  // ---------------- read path ----------------
  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = '0;
    case (w_offset)
      OFF_STATUS:    w_rdata = {r_frame_cnt, 11'd0, r_overflow, 4'(w_fifo_count)};
      OFF_KEY_EVENT: w_rdata = w_fifo_empty ? 32'd0 : {21'd0, 1'b1, w_fifo_rd};
      OFF_KEY_HELD:  w_rdata = {28'd0, r_held};
      default:       w_rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      io_rdata <= '0;
      io_hit   <= 1'b0;
    end else begin
      io_rdata <= w_in_window ? w_rdata : 32'd0;
      io_hit   <= w_in_window;
    end
  end

endmodule
